// File: rtl/trip_response.sv
// Trip-driven drive gate: ramps an interleaved IQ drive stream down to zero on a trip,
// parks it off through a holdoff, and ramps it back to full scale on a host rearm.
module trip_response #(
  parameter int DW = 16,
  parameter int SW = 16,
  parameter int HW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] drv_in,
  input  logic          gate_in,
  input  logic          trip_in,
  input  logic          rearm,
  input  logic [SW-1:0] ramp_step,
  input  logic [HW-1:0] holdoff,
  input  logic          clear_count,
  output logic [DW-1:0] drv_out,
  output logic          gate_out,
  output logic [2:0]    state,
  output logic          off,
  output logic [CW-1:0] trip_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_HOLDOFF   = 3'd4;

  localparam logic [SW-1:0] FULL      = {1'b1, {(SW-1){1'b0}}};
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};
  localparam int            PW        = DW + SW + 1;

  logic [2:0]          state_q, state_d;
  logic                off_q, off_d;
  logic [SW-1:0]       scale_q, scale_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SW-1:0]       pair_q, pair_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic [DW-1:0]       drv_q, drv_d;
  logic                gate_p_q, gate_p_d;
  logic                gate_q, gate_d;

  logic [SW:0]         up_sum_s;
  logic [SW-1:0]       scale_up_s;
  logic [SW-1:0]       scale_dn_s;
  logic                trip_ok_s;
  logic                unused_prod_bits;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      off_q    <= 1'b1;
      scale_q  <= '0;
      hold_q   <= '0;
      count_q  <= '0;
      pair_q   <= '0;
      prod_q   <= '0;
      drv_q    <= '0;
      gate_p_q <= 1'b0;
      gate_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      scale_q  <= scale_d;
      hold_q   <= hold_d;
      count_q  <= count_d;
      pair_q   <= pair_d;
      prod_q   <= prod_d;
      drv_q    <= drv_d;
      gate_p_q <= gate_p_d;
      gate_q   <= gate_d;
    end
  end

  // Saturating ramp arithmetic; a zero step jumps straight to the end point
  always_comb begin
    up_sum_s = {1'b0, scale_q} + {1'b0, ramp_step};
    if ((ramp_step == '0) || (up_sum_s >= {1'b0, FULL})) begin
      scale_up_s = FULL;
    end else begin
      scale_up_s = up_sum_s[SW-1:0];
    end
    if ((ramp_step == '0) || (ramp_step >= scale_q)) begin
      scale_dn_s = '0;
    end else begin
      scale_dn_s = scale_q - ramp_step;
    end
  end

  // Next-state, scale and holdoff logic; a trip wins over reaching full scale
  always_comb begin
    state_d = state_q;
    scale_d = scale_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        scale_d = '0;
        hold_d  = '0;
        if (rearm && !trip_in) begin
          state_d = S_RAMP_UP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RAMP_UP: begin
        if (trip_in) begin
          state_d = S_RAMP_DOWN;
        end else if (gate_in) begin
          scale_d = scale_up_s;
          if (scale_up_s == FULL) begin
            state_d = S_RUN;
          end else begin
            state_d = S_RAMP_UP;
          end
        end else begin
          state_d = S_RAMP_UP;
        end
      end
      S_RUN: begin
        scale_d = FULL;
        if (trip_in) begin
          state_d = S_RAMP_DOWN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RAMP_DOWN: begin
        if (gate_in) begin
          scale_d = scale_dn_s;
          if (scale_dn_s == '0) begin
            state_d = S_HOLDOFF;
            hold_d  = holdoff;
          end else begin
            state_d = S_RAMP_DOWN;
          end
        end else begin
          state_d = S_RAMP_DOWN;
        end
      end
      S_HOLDOFF: begin
        scale_d = '0;
        // Leaving when the counter would reach zero gives exactly `holdoff` cycles here
        if (hold_q <= HW'(1)) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else begin
          state_d = S_HOLDOFF;
          hold_d  = hold_q - HW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        scale_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Trip counter: only trips that start a ramp-down count; clear beats increment
  always_comb begin
    trip_ok_s = trip_in && ((state_q == S_RAMP_UP) || (state_q == S_RUN));
    if (clear_count) begin
      count_d = '0;
    end else if (trip_ok_s && (count_q != COUNT_MAX)) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Registered status outputs track the state register without extra delay
  always_comb begin
    if ((state_d == S_IDLE) || (state_d == S_HOLDOFF)) begin
      off_d = 1'b1;
    end else begin
      off_d = 1'b0;
    end
  end

  // Scale is captured on the I sample so its Q partner uses the same factor
  always_comb begin
    if (gate_in) begin
      pair_d = scale_d;
    end else begin
      pair_d = pair_q;
    end
    prod_d   = $signed(drv_in) * $signed({1'b0, pair_d});
    drv_d    = prod_q[DW+SW-2:SW-1];
    gate_p_d = gate_in;
    gate_d   = gate_p_q;
  end

  assign unused_prod_bits = ^{prod_q[PW-1:DW+SW-1], prod_q[SW-2:0]};

  assign drv_out    = drv_q;
  assign gate_out   = gate_q;
  assign state      = state_q;
  assign off        = off_q;
  assign trip_count = count_q;

endmodule

// File: tb/tb_trip_response.sv
// Directed self-checking bench for trip_response: ramp up, trip/holdoff, boundary
// sample values, ignored requests, trip priority and reset/clear behaviour.
module tb_trip_response;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] drv_in;
  logic               gate_in;
  logic               trip_in;
  logic               rearm;
  logic [15:0]        ramp_step;
  logic [15:0]        holdoff;
  logic               clear_count;
  logic signed [15:0] drv_out;
  logic               gate_out;
  logic [2:0]         state;
  logic               off;
  logic [15:0]        trip_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trip_response dut (
    .clk         (clk),
    .reset       (reset),
    .drv_in      (drv_in),
    .gate_in     (gate_in),
    .trip_in     (trip_in),
    .rearm       (rearm),
    .ramp_step   (ramp_step),
    .holdoff     (holdoff),
    .clear_count (clear_count),
    .drv_out     (drv_out),
    .gate_out    (gate_out),
    .state       (state),
    .off         (off),
    .trip_count  (trip_count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic signed [15:0] i_s, input logic signed [15:0] q_s);
    gate_in = 1'b1; drv_in = i_s; cyc();
    gate_in = 1'b0; drv_in = q_s; cyc();
    drv_in = 16'sd0;
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1; cyc(); rearm = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; drv_in = 16'sd0; gate_in = 1'b0; trip_in = 1'b0; rearm = 1'b0;
    ramp_step = 16'd0; holdoff = 16'd0; clear_count = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (off !== 1'b1) begin failures++; $display("FAIL reset_off got=%b exp=1", off); end
    checks++; if (drv_out !== 16'sd0) begin failures++; $display("FAIL reset_drv got=%0d exp=0", drv_out); end
    checks++; if (gate_out !== 1'b0) begin failures++; $display("FAIL reset_gate got=%b exp=0", gate_out); end
    checks++; if (trip_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", trip_count); end
  endtask

  task automatic test_ramp_up();
    ramp_step = 16'd8192;
    pulse_rearm();
    checks++; if (state !== 3'd1 || off !== 1'b0) begin failures++; $display("FAIL rearm_state got=%0d/%b exp=1/0", state, off); end
    send_pair(16'sd16000, -16'sd16000);
    checks++; if (drv_out !== 16'sd4000) begin failures++; $display("FAIL ramp1_drv got=%0d exp=4000", drv_out); end
    checks++; if (gate_out !== 1'b1) begin failures++; $display("FAIL ramp1_gate got=%b exp=1", gate_out); end
    for (int k = 0; k < 3; k++) send_pair(16'sd16000, -16'sd16000);
    checks++; if (state !== 3'd2 || off !== 1'b0) begin failures++; $display("FAIL run_state got=%0d/%b exp=2/0", state, off); end
    checks++; if (drv_out !== 16'sd16000) begin failures++; $display("FAIL run_i got=%0d exp=16000", drv_out); end
    cyc();
    checks++; if (drv_out !== -16'sd16000) begin failures++; $display("FAIL run_q got=%0d exp=-16000", drv_out); end
    checks++; if (gate_out !== 1'b0) begin failures++; $display("FAIL run_q_gate got=%b exp=0", gate_out); end
  endtask

  task automatic test_trip_holdoff();
    int bad;
    ramp_step = 16'd16384; holdoff = 16'd100;
    trip_in = 1'b1; cyc(); trip_in = 1'b0;
    checks++; if (state !== 3'd3 || trip_count !== 16'd1) begin failures++; $display("FAIL trip_accept got=%0d/%0d exp=3/1", state, trip_count); end
    send_pair(16'sd16000, -16'sd16000);
    checks++; if (drv_out !== 16'sd8000) begin failures++; $display("FAIL down_half got=%0d exp=8000", drv_out); end
    send_pair(16'sd16000, -16'sd16000);
    checks++; if (drv_out !== 16'sd0) begin failures++; $display("FAIL down_zero got=%0d exp=0", drv_out); end
    checks++; if (state !== 3'd4 || off !== 1'b1) begin failures++; $display("FAIL holdoff_enter got=%0d/%b exp=4/1", state, off); end
    bad = 0;
    for (int k = 0; k < 98; k++) begin
      cyc();
      if (state !== 3'd4) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL holdoff_len early_exit_cycles=%0d exp=0", bad); end
    cyc();
    checks++; if (state !== 3'd0 || off !== 1'b1) begin failures++; $display("FAIL holdoff_exit got=%0d/%b exp=0/1", state, off); end
    checks++; if (trip_count !== 16'd1) begin failures++; $display("FAIL trip_count1 got=%0d exp=1", trip_count); end
  endtask

  task automatic test_boundary_values();
    ramp_step = 16'd0;
    pulse_rearm();
    send_pair(-16'sd32768, -16'sd1);
    checks++; if (drv_out !== -16'sd32768) begin failures++; $display("FAIL min_full got=%0d exp=-32768", drv_out); end
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL step0_run got=%0d exp=2", state); end
    cyc();
    checks++; if (drv_out !== -16'sd1) begin failures++; $display("FAIL m1_full got=%0d exp=-1", drv_out); end
    ramp_step = 16'd16384; holdoff = 16'd5;
    trip_in = 1'b1; cyc(); trip_in = 1'b0;
    send_pair(-16'sd1, 16'sd0);
    checks++; if (drv_out !== -16'sd1) begin failures++; $display("FAIL m1_half got=%0d exp=-1", drv_out); end
    send_pair(16'sd0, 16'sd0);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL bnd_holdoff got=%0d exp=4", state); end
  endtask

  task automatic test_ignored_requests();
    int waited;
    pulse_rearm();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL rearm_in_holdoff got=%0d exp=4", state); end
    waited = 0;
    while (state !== 3'd0 && waited < 10) begin cyc(); waited++; end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL holdoff_timeout got=%0d exp=0", state); end
    send_pair(16'sd12345, -16'sd12345);
    checks++; if (drv_out !== 16'sd0 || state !== 3'd0) begin failures++; $display("FAIL idle_drive got=%0d/%0d exp=0/0", drv_out, state); end
    rearm = 1'b1; trip_in = 1'b1; cyc(); rearm = 1'b0; trip_in = 1'b0;
    checks++; if (state !== 3'd0 || trip_count !== 16'd2) begin failures++; $display("FAIL rearm_trip_idle got=%0d/%0d exp=0/2", state, trip_count); end
    cyc();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_stays got=%0d exp=0", state); end
  endtask

  task automatic test_trip_priority();
    int saw_run;
    ramp_step = 16'd8192; holdoff = 16'd0;
    pulse_rearm();
    for (int k = 0; k < 3; k++) send_pair(16'sd16000, -16'sd16000);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL pre_full got=%0d exp=1", state); end
    saw_run = 0;
    gate_in = 1'b1; drv_in = 16'sd16000; trip_in = 1'b1; cyc();
    checks++; if (state !== 3'd3 || trip_count !== 16'd3) begin failures++; $display("FAIL trip_prio got=%0d/%0d exp=3/3", state, trip_count); end
    gate_in = 1'b0; drv_in = -16'sd16000;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (state === 3'd2) saw_run++;
    end
    trip_in = 1'b0; drv_in = 16'sd0;
    checks++; if (saw_run != 0 || state !== 3'd3) begin failures++; $display("FAIL never_run run_cycles=%0d state=%0d exp=0/3", saw_run, state); end
    checks++; if (trip_count !== 16'd3) begin failures++; $display("FAIL repeat_trip got=%0d exp=3", trip_count); end
    ramp_step = 16'd0;
    send_pair(16'sd0, 16'sd0);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL holdoff0 got=%0d exp=0", state); end
  endtask

  task automatic test_reset_and_clear();
    ramp_step = 16'd8192;
    pulse_rearm();
    send_pair(16'sd16000, -16'sd16000);
    reset = 1'b1; gate_in = 1'b1; drv_in = 16'sd16000; cyc();
    checks++; if (state !== 3'd0 || drv_out !== 16'sd0 || off !== 1'b1) begin failures++; $display("FAIL mid_reset got=%0d/%0d/%b exp=0/0/1", state, drv_out, off); end
    checks++; if (trip_count !== 16'd0 || gate_out !== 1'b0) begin failures++; $display("FAIL mid_reset_cnt got=%0d/%b exp=0/0", trip_count, gate_out); end
    reset = 1'b0; gate_in = 1'b0; drv_in = 16'sd0;
    pulse_rearm();
    trip_in = 1'b1; cyc(); trip_in = 1'b0;
    checks++; if (trip_count !== 16'd1) begin failures++; $display("FAIL pre_clear got=%0d exp=1", trip_count); end
    ramp_step = 16'd0;
    send_pair(16'sd0, 16'sd0);
    ramp_step = 16'd8192;
    pulse_rearm();
    trip_in = 1'b1; clear_count = 1'b1; cyc(); trip_in = 1'b0; clear_count = 1'b0;
    checks++; if (trip_count !== 16'd0 || state !== 3'd3) begin failures++; $display("FAIL clear_prio got=%0d/%0d exp=0/3", trip_count, state); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_trip_holdoff();
    test_boundary_values();
    test_ignored_requests();
    test_trip_priority();
    test_reset_and_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
